reg_dump_unit: RTL and testbench
================================

REG_DUMP_UNIT -- requirements
Module: reg_dump_unit

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, register word width.
REQ-002 SHALL have parameter NB_REG, default 5, register index width.
REQ-003 SHALL have parameter N_REGS, default 32, number of registers dumped.
REQ-004 SHALL have parameter NB_BYTE, default 8, transmit byte width.
REQ-005 SHALL have port i_clock, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port i_reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port i_start, input, 1, dump request, sampled only in IDLE.
REQ-008 SHALL have port i_reg_data, input, NB_DATA, register bank debug read data for the index on o_br_addr.
REQ-009 SHALL have port o_br_enable, output, 1, steers o_br_addr onto bank read port A.
REQ-010 SHALL have port o_br_addr, output, NB_REG, register index being read.
REQ-011 SHALL have port o_tx_data, output, NB_BYTE, byte to the serial transmitter.
REQ-012 SHALL have port o_tx_valid, output, 1, o_tx_data valid.
REQ-013 SHALL have port i_tx_ready, input, 1, transmitter accepts byte.
REQ-014 SHALL have port o_busy, output, 1, dump in progress.
REQ-015 SHALL have port o_done, output, 1, one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, SETUP, CAPTURE, SEND, DONE.
REQ-017 IDLE: i_start=1 at an edge -> SETUP, index cleared to 0; i_start=0 -> stay.
REQ-018 SETUP: drive index on o_br_addr for one full cycle, then -> CAPTURE.
REQ-019 CAPTURE: at the edge ending the cycle, latch i_reg_data into a NB_DATA shift register, clear byte counter, -> SEND.
REQ-020 SEND: o_tx_valid=1, o_tx_data = shift register bits [NB_DATA-1 -: NB_BYTE] (MSB byte first).
REQ-021 A byte SHALL transfer only at an edge with o_tx_valid=1 and i_tx_ready=1; then shift left by NB_BYTE and increment byte counter.
REQ-022 While o_tx_valid=1 and i_tx_ready=0, o_tx_data and o_br_addr SHALL hold stable; no timeout.
REQ-023 After 4th byte (NB_DATA/NB_BYTE) transfers: index < N_REGS-1 -> increment index, -> SETUP; index = N_REGS-1 -> DONE.
REQ-024 DONE: o_done=1 for exactly one cycle, index cleared to 0, -> IDLE.
REQ-025 o_br_enable and o_busy SHALL be 1 in SETUP, CAPTURE, SEND; 0 in IDLE and DONE.
REQ-026 o_tx_valid SHALL be 1 only in SEND; o_tx_data SHALL be 0 outside SEND.
REQ-027 Latency: o_tx_valid rises after the 2nd rising edge following the edge that samples i_start.
REQ-028 With i_tx_ready held 1: 6 cycles per register, 192 cycles from leaving IDLE to DONE, 128 bytes total.
REQ-029 i_start while not IDLE SHALL be ignored, including in DONE.
REQ-030 Byte order: register 0 first through N_REGS-1, each MSB byte first; no header or trailer bytes.
REQ-031 Index SHALL never wrap past N_REGS-1; no byte for a nonexistent register.

Reset
REQ-032 i_reset=0 SHALL immediately, without a clock, force IDLE, index 0, byte counter 0, shift register 0, all outputs 0.
REQ-033 Reset mid-dump SHALL abort with no o_done pulse; next i_start restarts at register 0.
REQ-034 First state evaluation after i_reset deasserts SHALL be IDLE.

Verification
REQ-035 Reset: i_reset=0 mid-cycle with state SEND -> o_tx_valid, o_busy, o_br_enable, o_br_addr, o_tx_data, o_done all 0 before next edge.
REQ-036 Full dump, bank model reg k = 32'hA500_0000|k, i_tx_ready=1 -> 128 bytes A5,00,00,00,A5,00,00,01,...,A5,00,00,1F; o_done pulses once, 193 cycles after start edge.
REQ-037 Back-pressure: i_tx_ready=0 for 3 cycles during byte 2 of register 4 -> o_tx_data=8'h00 and o_br_addr=4 held, byte sent once, stream otherwise unchanged.
REQ-038 i_start pulsed during register 10 SEND and during DONE -> no restart, exactly 128 bytes, one o_done.
REQ-039 i_reset=0 during register 5, then release and i_start -> first byte A5 from register 0, no o_done from aborted dump.
REQ-040 Boundary: after register 31 byte 3 accepted -> DONE one cycle, o_br_addr=0, o_busy=0, no 129th o_tx_valid.

Source files
------------

// File: rtl/reg_dump_unit_if.sv
// ---------------------------------------------------------------------------
// reg_dump_unit_if
//   Bundle of the register-dump handshake and bus signals.
//   slave  modport : the dump unit (drives o_*, samples i_*)
//   master modport : the surrounding system (register bank + transmitter)
//   Signals:
//     i_start     dump request
//     i_reg_data  register bank debug read data for o_br_addr
//     i_tx_ready  transmitter accepts the presented byte
//     o_br_enable steer o_br_addr onto bank read port A
//     o_br_addr   register index being read
//     o_tx_data   byte to the serial transmitter
//     o_tx_valid  o_tx_data valid
//     o_busy      dump in progress
//     o_done      one-cycle completion pulse
// ---------------------------------------------------------------------------
interface reg_dump_unit_if #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_BYTE = 8
);
    logic               i_start;
    logic [NB_DATA-1:0] i_reg_data;
    logic               i_tx_ready;
    logic               o_br_enable;
    logic [NB_REG-1:0]  o_br_addr;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               o_tx_valid;
    logic               o_busy;
    logic               o_done;

    modport slave (
        input  i_start,
        input  i_reg_data,
        input  i_tx_ready,
        output o_br_enable,
        output o_br_addr,
        output o_tx_data,
        output o_tx_valid,
        output o_busy,
        output o_done
    );

    modport master (
        output i_start,
        output i_reg_data,
        output i_tx_ready,
        input  o_br_enable,
        input  o_br_addr,
        input  o_tx_data,
        input  o_tx_valid,
        input  o_busy,
        input  o_done
    );
endinterface

// File: rtl/reg_dump_unit.sv
// ---------------------------------------------------------------------------
// reg_dump_unit
//   Walks registers 0..N_REGS-1 of a register bank through its debug read
//   port and streams each word to a byte-wide transmitter, MSB byte first.
//   Ports:
//     i_clock  single clock, rising edge
//     i_reset  asynchronous active-low reset
//     bus      reg_dump_unit_if.slave (start, bank read port, tx handshake,
//              busy/done status)
// ---------------------------------------------------------------------------
module reg_dump_unit #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int N_REGS  = 32,
    parameter int NB_BYTE = 8
) (
    input  logic            i_clock,
    input  logic            i_reset,
    reg_dump_unit_if.slave  bus
);

    localparam int N_BYTES = NB_DATA / NB_BYTE;
    // One spare bit keeps the counter legal when a word is a single byte.
    localparam int NB_CNT  = $clog2(N_BYTES + 1);
    localparam logic [NB_REG-1:0] LAST_IDX  = NB_REG'(N_REGS - 1);
    localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(N_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        CAPTURE,
        SEND,
        DONE
    } state_t;

    state_t             r_state,    w_state_next;
    logic [NB_REG-1:0]  r_index,    w_index_next;
    logic [NB_CNT-1:0]  r_byte_cnt, w_byte_cnt_next;
    logic [NB_DATA-1:0] r_shift,    w_shift_next;
    logic               w_xfer;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= IDLE;
            r_index    <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_index    <= w_index_next;
            r_byte_cnt <= w_byte_cnt_next;
            r_shift    <= w_shift_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_index_next    = r_index;
        w_byte_cnt_next = r_byte_cnt;
        w_shift_next    = r_shift;
        w_xfer          = (r_state == SEND) && bus.i_tx_ready;

        case (r_state)
            IDLE: begin
                if (bus.i_start) begin
                    w_state_next = SETUP;
                    w_index_next = '0;
                end
            end
            // Address is held a full cycle so the bank read data settles.
            SETUP: begin
                w_state_next = CAPTURE;
            end
            CAPTURE: begin
                w_shift_next    = bus.i_reg_data;
                w_byte_cnt_next = '0;
                w_state_next    = SEND;
            end
            SEND: begin
                if (w_xfer) begin
                    w_shift_next    = r_shift << NB_BYTE;
                    w_byte_cnt_next = r_byte_cnt + NB_CNT'(1);
                    if (r_byte_cnt == LAST_BYTE) begin
                        if (r_index == LAST_IDX) begin
                            // Clear now so o_br_addr already reads 0 in DONE.
                            w_index_next = '0;
                            w_state_next = DONE;
                        end else begin
                            w_index_next = r_index + NB_REG'(1);
                            w_state_next = SETUP;
                        end
                    end
                end
            end
            DONE: begin
                w_index_next = '0;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Outputs decode straight from registers so reset clears them at once.
    assign bus.o_busy      = (r_state == SETUP) || (r_state == CAPTURE) || (r_state == SEND);
    assign bus.o_br_enable = (r_state == SETUP) || (r_state == CAPTURE) || (r_state == SEND);
    assign bus.o_br_addr   = r_index;
    assign bus.o_tx_valid  = (r_state == SEND);
    assign bus.o_tx_data   = (r_state == SEND) ? r_shift[NB_DATA-1 -: NB_BYTE] : '0;
    assign bus.o_done      = (r_state == DONE);

endmodule

// File: tb/tb_reg_dump_unit.sv
// ---------------------------------------------------------------------------
// tb_reg_dump_unit
//   Scoreboard bench for reg_dump_unit. Stimulus pushes the expected byte
//   stream; a negedge monitor pops and compares every accepted byte.
// ---------------------------------------------------------------------------
module tb_reg_dump_unit;

    localparam int NB_DATA = 32;
    localparam int NB_REG  = 5;
    localparam int N_REGS  = 32;
    localparam int NB_BYTE = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_err    = 0;
    int n_acc    = 0;
    int n_done   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    reg_dump_unit_if #(.NB_DATA(NB_DATA), .NB_REG(NB_REG), .NB_BYTE(NB_BYTE)) bus ();

    reg_dump_unit #(
        .NB_DATA (NB_DATA),
        .NB_REG  (NB_REG),
        .N_REGS  (N_REGS),
        .NB_BYTE (NB_BYTE)
    ) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Register bank model: reg k holds 32'hA500_0000 | k.
    assign bus.i_reg_data = 32'hA500_0000 | 32'(bus.o_br_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each accepted byte against the scoreboard queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_tx_valid && bus.i_tx_ready) begin
                n_acc++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL extra_byte: got %02h expected no byte at %0t",
                             bus.o_tx_data, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("tx_byte", 32'(bus.o_tx_data), 32'(mon_exp));
                end
            end else if (!bus.o_tx_valid) begin
                check("tx_data_idle_zero", 32'(bus.o_tx_data), 32'h0);
            end
            check("busy_eq_enable", 32'(bus.o_busy), 32'(bus.o_br_enable));
            if (bus.o_done) begin
                n_done++;
                check("done_not_busy", 32'(bus.o_busy), 32'h0);
            end
        end
    end

    task automatic push_dump();
        for (int r = 0; r < N_REGS; r++) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h00);
            exp_q.push_back(8'(r));
        end
    endtask

    // Returns #1 after the edge that samples i_start.
    task automatic start_dump();
        @(posedge clk);
        #1 bus.i_start = 1'b1;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
    endtask

    // Negedge k after the start edge follows edge k-1; o_done must be seen at
    // negedge exp_k and be low again one cycle later.
    task automatic wait_done(input int exp_k);
        int k;
        bit seen;
        seen = 1'b0;
        for (k = 1; k <= 2000; k++) begin
            @(negedge clk);
            if (bus.o_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_checks++;
            n_err++;
            $display("FAIL done_timeout: got no o_done expected one within 2000 cycles");
        end else begin
            check("done_cycle", 32'(k), 32'(exp_k));
            check("done_br_addr", 32'(bus.o_br_addr), 32'h0);
            check("done_busy", 32'(bus.o_busy), 32'h0);
            check("done_tx_valid", 32'(bus.o_tx_valid), 32'h0);
            check("done_br_enable", 32'(bus.o_br_enable), 32'h0);
            @(negedge clk);
            check("done_one_cycle", 32'(bus.o_done), 32'h0);
            check("idle_tx_valid", 32'(bus.o_tx_valid), 32'h0);
        end
    endtask

    task automatic wait_acc(input int base, input int target);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (n_acc - base == target) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            n_checks++;
            n_err++;
            $display("FAIL acc_timeout: got %0d bytes expected %0d", n_acc - base, target);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tx_valid"},  32'(bus.o_tx_valid),  32'h0);
        check({tag, "_busy"},      32'(bus.o_busy),      32'h0);
        check({tag, "_br_enable"}, 32'(bus.o_br_enable), 32'h0);
        check({tag, "_br_addr"},   32'(bus.o_br_addr),   32'h0);
        check({tag, "_tx_data"},   32'(bus.o_tx_data),   32'h0);
        check({tag, "_done"},      32'(bus.o_done),      32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.i_start    = 1'b0;
        bus.i_tx_ready = 1'b1;

        // Reset state.
        #23;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(bus.o_busy), 32'h0);

        // Full dump with ready held high.
        base = n_acc;
        push_dump();
        start_dump();
        wait_done(193);
        check("full_bytes", 32'(n_acc - base), 32'd128);
        check("full_queue_empty", 32'(exp_q.size()), 32'd0);
        check("full_done_count", 32'(n_done), 32'd1);

        // Back-pressure: stall byte 2 of register 4 for three cycles.
        base = n_acc;
        push_dump();
        fork
            begin
                start_dump();
                wait_done(196);
            end
            begin
                wait_acc(base, 18);
                bus.i_tx_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("bp_tx_valid", 32'(bus.o_tx_valid), 32'h1);
                    check("bp_tx_data",  32'(bus.o_tx_data),  32'h00);
                    check("bp_br_addr",  32'(bus.o_br_addr),  32'd4);
                    @(posedge clk);
                    #1;
                end
                bus.i_tx_ready = 1'b1;
            end
        join
        check("bp_bytes", 32'(n_acc - base), 32'd128);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        check("bp_done_count", 32'(n_done), 32'd2);

        // i_start during register 10 SEND and during DONE is ignored.
        base = n_acc;
        push_dump();
        fork
            begin
                start_dump();
                wait_done(193);
            end
            begin
                wait_acc(base, 41);
                check("ign_in_send", 32'(bus.o_tx_valid), 32'h1);
                bus.i_start = 1'b1;
                @(posedge clk);
                #1 bus.i_start = 1'b0;
            end
            begin
                wait_acc(base, 100);
                for (int i = 0; i < 500; i++) begin
                    @(negedge clk);
                    if (bus.o_done) break;
                end
                bus.i_start = 1'b1;
                @(posedge clk);
                #1 bus.i_start = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        check("ign_idle_busy", 32'(bus.o_busy), 32'h0);
        check("ign_bytes", 32'(n_acc - base), 32'd128);
        check("ign_queue_empty", 32'(exp_q.size()), 32'd0);
        check("ign_done_count", 32'(n_done), 32'd3);

        // Reset mid-dump during register 5, then a clean restart.
        base = n_acc;
        push_dump();
        start_dump();
        wait_acc(base, 21);
        check("abort_in_send", 32'(bus.o_tx_valid), 32'h1);
        check("abort_br_addr", 32'(bus.o_br_addr), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_no_done", 32'(n_done), 32'd3);
        check("abort_idle_busy", 32'(bus.o_busy), 32'h0);
        base = n_acc;
        push_dump();
        start_dump();
        wait_done(193);
        check("restart_bytes", 32'(n_acc - base), 32'd128);
        check("restart_queue_empty", 32'(exp_q.size()), 32'd0);
        check("restart_done_count", 32'(n_done), 32'd4);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
